// File: rtl/udp_tx_fifo_sched_if.sv
// Byte-stream bus between the packet scheduler, the read side of the
// async byte FIFO and the UDP TX engine. The scheduler is the master.
interface udp_tx_fifo_sched_if #(
  parameter int DEPTH_WIDTH = 11,
  parameter int LEN_WIDTH   = 11
);
  logic                   fifo_rd_en;
  logic [7:0]             fifo_rd_data;
  logic                   fifo_rd_empty;
  logic [DEPTH_WIDTH:0]   fifo_rd_water_level;
  logic                   tx_req;
  logic [LEN_WIDTH-1:0]   tx_len;
  logic                   tx_ack;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_last;
  logic                   tx_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
    output tx_req, tx_len,
    input  tx_ack,
    output tx_data, tx_valid, tx_last,
    input  tx_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
    input  tx_req, tx_len,
    output tx_ack,
    input  tx_data, tx_valid, tx_last,
    output tx_ready
  );
endinterface

// File: rtl/udp_tx_fifo_sched.sv
// Read-side packet scheduler for the UDP OSD byte FIFO. Decides when a
// payload is ready (full length, timeout or flush), requests a send and
// drains exactly tx_len bytes through a 2-entry skid buffer that hides
// the FIFO's one-cycle read latency.
module udp_tx_fifo_sched #(
  parameter int DEPTH_WIDTH    = 11,
  parameter int LEN_WIDTH      = 11,
  parameter int PKT_MAX        = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic [LEN_WIDTH-1:0] cfg_pkt_len,
  input  logic                 flush,
  udp_tx_fifo_sched_if.master  bus,
  output logic                 busy,
  output logic [15:0]          pkt_cnt
);
  localparam int LVL_W = DEPTH_WIDTH + 1;
  localparam int CMP_W = (LVL_W > LEN_WIDTH) ? LVL_W : LEN_WIDTH;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] eff_len;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] rd_left;
  logic [LEN_WIDTH-1:0] tx_left;
  logic [CMP_W-1:0]     level_ext;
  logic [CMP_W-1:0]     len_ext;
  logic [TMR_W-1:0]     timer;
  logic                 flush_pend;
  logic [7:0]           skid_head;
  logic [7:0]           skid_tail;
  logic [1:0]           skid_cnt;
  logic                 rd_pend;
  logic [2:0]           occ;
  logic [2:0]           space_used;
  logic                 pop;
  logic                 rd_issue;
  logic                 level_zero;
  logic                 full_ready;
  logic                 start_full;
  logic                 start_part;

  // Clamp the configured length: zero or oversize means a maximum-size packet.
  always_comb begin
    eff_len = cfg_pkt_len;
    if (cfg_pkt_len == '0 || 32'(cfg_pkt_len) > 32'(PKT_MAX))
      eff_len = LEN_WIDTH'(PKT_MAX);
  end

  // Send decision and stream-side handshake terms.
  always_comb begin
    level_ext  = CMP_W'(bus.fifo_rd_water_level);
    len_ext    = CMP_W'(eff_len);
    level_zero = (bus.fifo_rd_water_level == '0);
    full_ready = (level_ext >= len_ext);
    start_full = (state == ST_IDLE) && full_ready;
    start_part = (state == ST_IDLE) && !full_ready && !level_zero &&
                 ((timer == TMR_W'(TIMEOUT_CYCLES)) || flush_pend);
    occ        = {1'b0, skid_cnt} + {2'b00, rd_pend};
    pop        = bus.tx_valid && bus.tx_ready;
    space_used = occ - {2'b00, pop};
    rd_issue   = (state == ST_STREAM) && (rd_left != '0) &&
                 !bus.fifo_rd_empty && (space_used < 3'd2);
  end

  // Output view: an empty skid buffer passes the in-flight FIFO byte straight through.
  always_comb begin
    bus.fifo_rd_en = rd_issue;
    bus.tx_req     = (state == ST_REQ);
    bus.tx_len     = len_q;
    bus.tx_valid   = (state == ST_STREAM) && ((skid_cnt != 2'd0) || rd_pend);
    bus.tx_data    = 8'h00;
    if (skid_cnt != 2'd0)
      bus.tx_data = skid_head;
    else if (rd_pend)
      bus.tx_data = bus.fifo_rd_data;
    bus.tx_last    = bus.tx_valid && (tx_left == LEN_WIDTH'(1));
    busy           = (state != ST_IDLE);
  end

  // Main FSM: pick a length, wait for the engine's ack, then count bytes out.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      rd_left <= '0;
      tx_left <= '0;
      pkt_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_full) begin
            len_q <= eff_len;
            state <= ST_REQ;
          end else if (start_part) begin
            len_q <= LEN_WIDTH'(bus.fifo_rd_water_level);
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.tx_ack) begin
            rd_left <= len_q;
            tx_left <= len_q;
            state   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (rd_issue)
            rd_left <= rd_left - 1'b1;
          if (pop)
            tx_left <= tx_left - 1'b1;
          if (pop && bus.tx_last) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Residual-data timer and pending flush; an empty FIFO discards both.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      timer      <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (state != ST_IDLE || start_full || start_part || level_zero)
        timer <= '0;
      else if (!full_ready)
        timer <= timer + 1'b1;
      if (state == ST_IDLE && (level_zero || start_full || start_part))
        flush_pend <= 1'b0;
      else if (flush)
        flush_pend <= 1'b1;
    end
  end

  // Skid buffer: absorbs the byte returned one cycle after each read.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      skid_head <= 8'h00;
      skid_tail <= 8'h00;
      skid_cnt  <= 2'd0;
      rd_pend   <= 1'b0;
    end else begin
      rd_pend  <= rd_issue;
      skid_cnt <= skid_cnt + {1'b0, rd_pend} - {1'b0, pop};
      if (pop && skid_cnt == 2'd2)
        skid_head <= skid_tail;
      if (rd_pend) begin
        if (skid_cnt == 2'd0 && !pop)
          skid_head <= bus.fifo_rd_data;
        else if (skid_cnt == 2'd1 && pop)
          skid_head <= bus.fifo_rd_data;
        else if (skid_cnt == 2'd1 && !pop)
          skid_tail <= bus.fifo_rd_data;
        else if (skid_cnt == 2'd2 && pop)
          skid_tail <= bus.fifo_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_udp_tx_fifo_sched.sv
// Directed bench for udp_tx_fifo_sched with a behavioural FIFO and TX engine.
module tb_udp_tx_fifo_sched;
  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic [10:0] cfg_pkt_len = 11'd16;
  logic        flush = 1'b0;
  logic        tx_ack = 1'b0;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic [15:0] pkt_cnt;

  logic [7:0]  mem [0:4095];
  logic [7:0]  fifo_data = 8'h00;
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_count = 0;
  int          last_cnt = 0;
  int          hold_viol = 0;
  int          cyc = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        prev_last = 1'b0;
  logic [7:0]  mon_data[$];
  logic        mon_last[$];
  int          mon_cyc[$];

  int tests_run = 0;
  int tests_failed = 0;

  udp_tx_fifo_sched_if #(.DEPTH_WIDTH(11), .LEN_WIDTH(11)) bus ();

  udp_tx_fifo_sched #(
    .DEPTH_WIDTH(11), .LEN_WIDTH(11), .PKT_MAX(1024), .TIMEOUT_CYCLES(100)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .cfg_pkt_len(cfg_pkt_len),
    .flush(flush), .bus(bus), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  assign bus.fifo_rd_data        = fifo_data;
  assign bus.fifo_rd_empty       = (wr_ptr == rd_ptr);
  assign bus.fifo_rd_water_level = 12'(wr_ptr - rd_ptr);
  assign bus.tx_ack              = tx_ack;
  assign bus.tx_ready            = tx_ready;

  // FIFO read port model and output monitor.
  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en) begin
      fifo_data <= mem[rd_ptr[11:0]];
      rd_ptr    <= rd_ptr + 1;
      rd_count  <= rd_count + 1;
    end
    if (rd_rst_n) begin
      if (stall_prev && (!bus.tx_valid || bus.tx_data !== prev_data || bus.tx_last !== prev_last))
        hold_viol <= hold_viol + 1;
      stall_prev <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
      prev_last  <= bus.tx_last;
      if (bus.tx_valid && bus.tx_ready) begin
        mon_data.push_back(bus.tx_data);
        mon_last.push_back(bus.tx_last);
        mon_cyc.push_back(cyc);
        if (bus.tx_last) last_cnt <= last_cnt + 1;
      end
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic do_reset();
    rd_rst_n = 1'b0; tx_ack = 1'b0; tx_ready = 1'b0; flush = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    wr_ptr = rd_ptr;
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    mon_data.delete(); mon_last.delete(); mon_cyc.delete();
  endtask

  task automatic write_bytes(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[11:0]] = 8'(start + i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic wait_req(input int max_cyc, output int cycles, output bit seen);
    cycles = 0;
    while (!bus.tx_req && cycles < max_cyc) begin
      @(negedge rd_clk);
      cycles++;
    end
    seen = bus.tx_req;
  endtask

  task automatic serve(input bit toggle, output bit done);
    int start;
    start = last_cnt;
    @(negedge rd_clk); tx_ack = 1'b1;
    @(negedge rd_clk); tx_ack = 1'b0;
    for (int n = 0; n < 5000 && last_cnt == start; n++) begin
      tx_ready = toggle ? ~tx_ready : 1'b1;
      @(negedge rd_clk);
    end
    done = (last_cnt != start);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bus.tx_req, bus.tx_valid, bus.tx_last, bus.fifo_rd_en, busy} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {bus.tx_req, bus.tx_valid, bus.tx_last, bus.fifo_rd_en, busy});
    end
    tests_run++;
    if (pkt_cnt !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt);
    end
    tests_run++;
    if (bus.tx_len !== 11'd0 || bus.tx_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_len_data: got len %0d data %0h expected 0 0", bus.tx_len, bus.tx_data);
    end
  endtask

  task automatic test_full_packet();
    int cycles, rd0, errs; bit seen, done;
    do_reset();
    cfg_pkt_len = 11'd16;
    rd0 = rd_count;
    write_bytes(16, 0);
    wait_req(50, cycles, seen);
    tests_run++;
    if (!seen || cycles != 1) begin
      tests_failed++; $display("[TB] FAIL full_req_latency: got %0d seen %0d expected 1", cycles, seen);
    end
    tests_run++;
    if (bus.tx_len !== 11'd16) begin
      tests_failed++; $display("[TB] FAIL full_tx_len: got %0d expected 16", bus.tx_len);
    end
    serve(1'b0, done);
    errs = 0;
    for (int i = 0; i < mon_data.size(); i++)
      if (mon_data[i] !== 8'(i) || mon_last[i] !== (i == 15)) errs++;
    tests_run++;
    if (!done || mon_data.size() != 16 || errs != 0) begin
      tests_failed++;
      $display("[TB] FAIL full_data: got %0d bytes %0d bad expected 16 bytes 0 bad", mon_data.size(), errs);
    end
    tests_run++;
    if (mon_data.size() != 16 || mon_cyc[15] - mon_cyc[0] != 15) begin
      tests_failed++; $display("[TB] FAIL full_consecutive: got %0d bytes expected 16 over 16 cycles", mon_data.size());
    end
    tests_run++;
    if (rd_count - rd0 != 16) begin
      tests_failed++; $display("[TB] FAIL full_reads: got %0d expected 16", rd_count - rd0);
    end
    tests_run++;
    if (pkt_cnt !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL full_pkt_cnt: got %0d expected 1", pkt_cnt);
    end
  endtask

  task automatic test_back_pressure();
    int cycles, rd0, errs; bit seen, done;
    do_reset();
    cfg_pkt_len = 11'd16;
    rd0 = rd_count;
    write_bytes(16, 8'h40);
    wait_req(50, cycles, seen);
    serve(1'b1, done);
    errs = 0;
    for (int i = 0; i < mon_data.size(); i++)
      if (mon_data[i] !== 8'(8'h40 + i) || mon_last[i] !== (i == 15)) errs++;
    tests_run++;
    if (!seen || !done || mon_data.size() != 16 || errs != 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_data: got %0d bytes %0d bad expected 16 bytes 0 bad", mon_data.size(), errs);
    end
    tests_run++;
    if (hold_viol != 0) begin
      tests_failed++; $display("[TB] FAIL bp_hold_stable: got %0d violations expected 0", hold_viol);
    end
    repeat (4) @(negedge rd_clk);
    tests_run++;
    if (rd_count - rd0 != 16) begin
      tests_failed++; $display("[TB] FAIL bp_reads: got %0d expected 16", rd_count - rd0);
    end
    tests_run++;
    if (pkt_cnt !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL bp_pkt_cnt: got %0d expected 1", pkt_cnt);
    end
  endtask

  task automatic test_timeout();
    int cycles, errs; bit seen, done;
    do_reset();
    cfg_pkt_len = 11'd64;
    write_bytes(5, 8'hA0);
    wait_req(300, cycles, seen);
    tests_run++;
    if (!seen || cycles != 101) begin
      tests_failed++; $display("[TB] FAIL timeout_latency: got %0d seen %0d expected 101", cycles, seen);
    end
    tests_run++;
    if (bus.tx_len !== 11'd5) begin
      tests_failed++; $display("[TB] FAIL timeout_tx_len: got %0d expected 5", bus.tx_len);
    end
    serve(1'b0, done);
    errs = 0;
    for (int i = 0; i < mon_data.size(); i++)
      if (mon_data[i] !== 8'(8'hA0 + i) || mon_last[i] !== (i == 4)) errs++;
    tests_run++;
    if (!done || mon_data.size() != 5 || errs != 0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_data: got %0d bytes %0d bad expected 5 bytes 0 bad", mon_data.size(), errs);
    end
  endtask

  task automatic test_flush_clamp();
    int cycles, errs; bit seen, done;
    do_reset();
    cfg_pkt_len = 11'd0;
    write_bytes(3, 8'h30);
    @(negedge rd_clk); flush = 1'b1;
    @(negedge rd_clk); flush = 1'b0;
    wait_req(50, cycles, seen);
    tests_run++;
    if (!seen || cycles != 1) begin
      tests_failed++; $display("[TB] FAIL flush_latency: got %0d seen %0d expected 1", cycles, seen);
    end
    tests_run++;
    if (bus.tx_len !== 11'd3) begin
      tests_failed++; $display("[TB] FAIL flush_tx_len: got %0d expected 3", bus.tx_len);
    end
    serve(1'b0, done);
    errs = 0;
    for (int i = 0; i < mon_data.size(); i++)
      if (mon_data[i] !== 8'(8'h30 + i) || mon_last[i] !== (i == 2)) errs++;
    tests_run++;
    if (!done || mon_data.size() != 3 || errs != 0) begin
      tests_failed++;
      $display("[TB] FAIL flush_data: got %0d bytes %0d bad expected 3 bytes 0 bad", mon_data.size(), errs);
    end
    @(negedge rd_clk); flush = 1'b1;
    @(negedge rd_clk); flush = 1'b0;
    wait_req(150, cycles, seen);
    tests_run++;
    if (seen) begin
      tests_failed++; $display("[TB] FAIL flush_empty_dropped: got tx_req 1 expected 0");
    end
    write_bytes(2, 8'h50);
    wait_req(300, cycles, seen);
    tests_run++;
    if (!seen || cycles != 101) begin
      tests_failed++; $display("[TB] FAIL flush_no_stale: got %0d seen %0d expected 101", cycles, seen);
    end
    serve(1'b0, done);
  endtask

  task automatic test_length_cap();
    int cycles, rd0, errs, len1, len2; bit seen1, seen2, done1, done2;
    do_reset();
    cfg_pkt_len = 11'd2000;
    rd0 = rd_count;
    write_bytes(2048, 0);
    wait_req(50, cycles, seen1);
    len1 = int'(bus.tx_len);
    serve(1'b0, done1);
    wait_req(50, cycles, seen2);
    len2 = int'(bus.tx_len);
    serve(1'b0, done2);
    tests_run++;
    if (!seen1 || !seen2 || len1 != 1024 || len2 != 1024) begin
      tests_failed++; $display("[TB] FAIL cap_tx_len: got %0d/%0d expected 1024/1024", len1, len2);
    end
    errs = 0;
    for (int i = 0; i < mon_data.size(); i++)
      if (mon_data[i] !== 8'(i) || mon_last[i] !== (i == 1023 || i == 2047)) errs++;
    tests_run++;
    if (!done1 || !done2 || mon_data.size() != 2048 || errs != 0) begin
      tests_failed++;
      $display("[TB] FAIL cap_data: got %0d bytes %0d bad expected 2048 bytes 0 bad", mon_data.size(), errs);
    end
    tests_run++;
    if (rd_count - rd0 != 2048) begin
      tests_failed++; $display("[TB] FAIL cap_reads: got %0d expected 2048", rd_count - rd0);
    end
    tests_run++;
    if (pkt_cnt !== 16'd2) begin
      tests_failed++; $display("[TB] FAIL cap_pkt_cnt: got %0d expected 2", pkt_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    int cycles, n; bit seen, done;
    do_reset();
    cfg_pkt_len = 11'd16;
    write_bytes(32, 0);
    wait_req(50, cycles, seen);
    serve(1'b0, done);
    wait_req(50, cycles, seen);
    @(negedge rd_clk); tx_ack = 1'b1;
    @(negedge rd_clk); tx_ack = 1'b0; tx_ready = 1'b1;
    n = 0;
    while (mon_data.size() < 22 && n < 200) begin
      @(negedge rd_clk);
      n++;
    end
    tests_run++;
    if (mon_data.size() != 22 || pkt_cnt !== 16'd1 || !bus.tx_valid) begin
      tests_failed++;
      $display("[TB] FAIL mid_setup: got %0d bytes pkt_cnt %0d valid %0d expected 22 1 1",
               mon_data.size(), pkt_cnt, bus.tx_valid);
    end
    rd_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.tx_req, bus.tx_valid, bus.tx_last, bus.fifo_rd_en, busy, bus.tx_data, bus.tx_len, pkt_cnt} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs: got req %0d valid %0d last %0d rd_en %0d busy %0d data %0h len %0d cnt %0d expected all 0",
               bus.tx_req, bus.tx_valid, bus.tx_last, bus.fifo_rd_en, busy, bus.tx_data, bus.tx_len, pkt_cnt);
    end
    tx_ready = 1'b0;
    @(negedge rd_clk); @(negedge rd_clk);
    rd_rst_n = 1'b1;
    repeat (3) @(negedge rd_clk);
    tests_run++;
    if (busy !== 1'b0 || pkt_cnt !== 16'd0 || bus.tx_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_after_release: got busy %0d pkt_cnt %0d req %0d expected 0 0 0", busy, pkt_cnt, bus.tx_req);
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_back_pressure();
    test_timeout();
    test_flush_clamp();
    test_length_cap();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/udp_tx_fifo_sched.md
# udp_tx_fifo_sched

Read-side packet scheduler for the 2048x8 async byte FIFO in the UDP OSD path. It watches the FIFO's read water level and decides when a UDP payload is ready: a full packet of `cfg_pkt_len` bytes, or a shorter residual after a timeout or flush. It then requests a send from the UDP TX engine and drains exactly that many bytes into a valid/ready byte stream. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer.

## Interface
- `DEPTH_WIDTH`, default 11: FIFO read depth width. The water-level input is `DEPTH_WIDTH+1` bits.
- `LEN_WIDTH`, default 11: width of the packet length fields.
- `PKT_MAX`, default 1024: largest payload in bytes.
- `TIMEOUT_CYCLES`, default 65535: idle cycles with residual data before a forced send.
- `rd_clk` in, 1: the single clock, same as the FIFO read clock.
- `rd_rst_n` in, 1: reset, asynchronous and active-low.
- `cfg_pkt_len` in, `LEN_WIDTH`: target payload length. Sampled only in IDLE.
- `flush` in, 1: single-cycle pulse that requests a send of the residual bytes.
- `fifo_rd_en` out, 1: FIFO read enable. It is also the FIFO read clock enable.
- `fifo_rd_data` in, 8: FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_empty` in, 1: FIFO empty flag.
- `fifo_rd_water_level` in, `DEPTH_WIDTH+1`: FIFO occupancy as seen from the read side.
- `tx_req` out, 1: send request to the UDP TX engine.
- `tx_len` out, `LEN_WIDTH`: payload length of the request. Stable while `tx_req` is high.
- `tx_ack` in, 1: UDP TX engine accepts the request.
- `tx_data` out, 8: payload byte.
- `tx_valid` out, 1: `tx_data` is valid.
- `tx_last` out, 1: marks the final byte of the packet.
- `tx_ready` in, 1: downstream accepts the byte.
- `busy` out, 1: high in any state other than IDLE.
- `pkt_cnt` out, 16: count of completed packets. Wraps at 65535 to 0.

## Operation
- Reset value of every output is 0. State resets to IDLE. The timer, the counters and the skid buffer are all cleared.
- Effective length: `L = cfg_pkt_len`, except that 0 or any value above `PKT_MAX` is forced to `PKT_MAX`.
- **IDLE** (each cycle, priority order):
  - If level ≥ L: latch `tx_len = L`, go to REQ.
  - Else, if level ≠ 0 and (timer == `TIMEOUT_CYCLES` or `flush_pend`): latch `tx_len = level`, go to REQ.
  - Timer: increments each cycle while 0 < level < L. Clears when level == 0 and whenever IDLE is left.
  - `flush_pend`: set by `flush`. Cleared on entering REQ, or immediately if level == 0, so a flush of an empty FIFO is dropped.
- **REQ**:
  - `tx_req` = 1 and `tx_len` is held.
  - On `tx_ack`: load `rd_left = tx_len` and `tx_left = tx_len`, go to STREAM. No timeout.
- **STREAM**:
  - `occ` = number of skid entries held plus 1 if a read was issued in the previous cycle.
  - `pop` = `tx_valid && tx_ready`.
  - `fifo_rd_en` = (`rd_left` ≠ 0) && !`fifo_rd_empty` && (`occ` − `pop`) < 2.
  - Each issued read decrements `rd_left`. Read data is written into the skid buffer the following cycle.
  - `tx_data`/`tx_valid` present the head of the skid buffer.
  - Each pop decrements `tx_left`. `tx_last` = `tx_valid` && (`tx_left` == 1).
  - When the pop with `tx_last` high occurs: `pkt_cnt` +1, go to IDLE.
- Because `rd_left` caps the reads, the block never reads beyond `tx_len` bytes.
- Empty mid-packet (the water level can under-report writes because of the CDC lag): `fifo_rd_en` simply deasserts and resumes when data arrives. No error is raised.
- Reset mid-packet aborts the current packet. Bytes already read from the FIFO are lost; this is accepted behaviour.
- `flush` arriving while not in IDLE sets `flush_pend`, which is serviced on the return to IDLE.

## Timing
- Level ≥ L to `tx_req` high: 1 cycle.
- `tx_ack` to first `fifo_rd_en`: 1 cycle.
- First `fifo_rd_en` to first `tx_valid`: 1 cycle.
- Throughput: sustained 1 byte per cycle while `tx_ready` is held high and the FIFO is non-empty.
- `tx_valid`/`tx_data`/`tx_last` hold steady while `tx_ready` is low (AXIS-style rule).
- Timeout send: occurs `TIMEOUT_CYCLES`+1 cycles after the level first becomes nonzero, provided it stays below L.
- Return from the final pop to IDLE: 1 cycle. A new evaluation starts in the next cycle.

## Test plan
- **Full packet:** `cfg_pkt_len`=16, write 16 bytes 0x00..0x0F, `tx_ack` 1 cycle after `tx_req`, `tx_ready`=1 → `tx_len`=16; bytes 0x00..0x0F on consecutive cycles; `tx_last` on 0x0F; exactly 16 `fifo_rd_en`; `pkt_cnt`=1.
- **Back-pressure:** same 16 bytes, `tx_ready` toggled 1/0 each cycle → data is held stable during the low cycles; order is intact; no extra reads; `pkt_cnt`=1.
- **Timeout:** `TIMEOUT_CYCLES`=100, write 5 bytes, `cfg_pkt_len`=64 → `tx_req` with `tx_len`=5 about 101 cycles after the first byte; 5 bytes out with `tx_last` on the 5th.
- **Flush and clamp:** `cfg_pkt_len`=0, write 3 bytes, then `flush` pulse → `tx_len`=3. Separately, `flush` with an empty FIFO → no `tx_req`.
- **Length cap:** `PKT_MAX`=1024, write 2048 bytes → two packets of `tx_len`=1024 each; `pkt_cnt`=2; total of 2048 `fifo_rd_en`.
- **Reset mid-packet:** assert `rd_rst_n`=0 during byte 7 of 16 → all outputs are 0 at once; after release the state is IDLE and `pkt_cnt`=0.
